aes_key_expand: RTL and testbench
=================================

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port start, input, 1, request expansion of key_in; sampled only in IDLE.
REQ-004 SHALL have port key_in, input, 128, cipher key; w0=key_in[127:96] ... w3=key_in[31:0].
REQ-005 SHALL have port round_key, output, 128, current round key {w4r..w4r+3}.
REQ-006 SHALL have port round_num, output, 4, index 0..10 of round_key.
REQ-007 SHALL have port key_valid, output, 1, round_key/round_num valid.
REQ-008 SHALL have port key_ready, input, 1, consumer accepts round key when key_valid and key_ready are both 1.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse after round 10 accepted.
REQ-011 SHALL have port rd_addr, input, 4, stored-key read index (see Configuration).
REQ-012 SHALL have port rd_key, output, 128, stored round key at rd_addr (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, EMIT, G_START, G_WAIT, EXPAND, DONE.
REQ-014 IDLE: start=1 -> LOAD; start ignored in any other state.
REQ-015 LOAD: latch key_in into w0..w3; round counter=0 -> EMIT (1 cycle).
REQ-016 EMIT: key_valid=1, round_key held stable; key_valid & key_ready -> G_START if round<10, else DONE; key_ready=0 -> stay in EMIT, outputs unchanged.
REQ-017 G_START: one-cycle g_start pulse to sub-module with word w3 and round+1 -> G_WAIT.
REQ-018 G_WAIT: hold until g_done=1 -> EXPAND; no timeout.
REQ-019 EXPAND: n0=w0^g; n1=w1^n0; n2=w2^n1; n3=w3^n2; round+=1 -> EMIT (1 cycle).
REQ-020 DONE: done=1 for exactly one cycle -> IDLE; round_key keeps round-10 value.
REQ-021 Round counter 4-bit, range 0..10, never wraps; round_num equals counter.
REQ-022 All XORs bitwise 32-bit; no carries.
REQ-023 Minimum latency start-to-first key_valid = 2 cycles; between keys = 3 cycles + G latency with key_ready tied 1.
REQ-024 start coincident with key_valid/DONE ignored; no queueing.

Reset
REQ-025 rst=1 at any clock edge, including mid-expansion, SHALL force IDLE; key_valid=0, done=0, busy=0, round_num=0, round_key=0; sub-module aborted and reset.
REQ-026 Reset SHALL take priority over start and key_ready in the same cycle.

Configuration
REQ-027 Macro KEYEXP_STORE_EN SHALL select key storage.
REQ-028 With KEYEXP_STORE_EN: 11x128 register array; each key written on EMIT entry; rd_key=array[rd_addr] combinationally; rd_addr>10 -> rd_key=0; array cleared by rst.
REQ-029 Without KEYEXP_STORE_EN: no array; rd_key tied 0; rd_addr ignored; ports remain present.

Structure
REQ-030 Shared package aes_pkg SHALL hold the FSM state typedef, Rcon table (rounds 1..10: 01,02,04,08,10,20,40,80,1B,36), and word/key width constants.
REQ-031 Sub-module g_word_unit SHALL compute RotWord, SubWord, Rcon XOR with g_start/g_done handshake; aes_key_expand SHALL NOT depend on its exact latency.

Verification
REQ-032 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, key_ready=1 -> round 1 a0fafe1788542cb123a339392a6c7605, round 10 d014f9a8c9ee2589e13f0cc8b6630ca6, done pulse once.
REQ-033 Key all-zero -> round 0 all-zero, round 1 62636363626363636263636362636363.
REQ-034 key_ready low 5 cycles during round 3 EMIT -> round_key/round_num stable, no skipped or repeated rounds.
REQ-035 rst asserted in G_WAIT of round 5 -> next cycle IDLE, outputs zero; new start with FIPS key -> correct full sequence.
REQ-036 start pulsed mid-expansion -> ignored, sequence unchanged.
REQ-037 KEYEXP_STORE_EN built: after FIPS run rd_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; rd_addr=12 -> 0; without macro rd_key=0 always.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-expansion definitions: widths, FSM state type, Rcon table,
// and GF(2^8) helpers used by the S-box.
package aes_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned KEY_W      = 128;
  localparam int unsigned LAST_ROUND = 10;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [KEY_W-1:0]  key_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    G_START,
    G_WAIT,
    EXPAND,
    DONE
  } ke_state_t;

  // Round constant for rounds 1..10; zero outside that range.
  function automatic logic [BYTE_W-1:0] rcon(input logic [3:0] round);
    logic [BYTE_W-1:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] x;
    logic [BYTE_W-1:0] bb;
    p  = '0;
    x  = a;
    bb = b;
    for (int unsigned i = 0; i < BYTE_W; i++) begin
      if (bb[0]) p = p ^ x;
      x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (a^254, which maps 0 to 0) then affine map.
  function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] a);
    logic [BYTE_W-1:0] inv;
    logic [BYTE_W-1:0] p;
    inv = 8'h01;
    p   = a;
    for (int unsigned i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_expand_g_word_unit.sv
// g_word_unit: computes SubWord(RotWord(w)) ^ {Rcon,0,0,0} using a single
// shared S-box, one byte per cycle; g_done pulses when g_result is valid.
module g_word_unit
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       g_start,
  input  word_t      g_word,
  input  logic [3:0] g_round,
  output logic       g_done,
  output word_t      g_result
);

  logic                running;
  logic [1:0]          cnt;
  word_t               acc;
  logic [BYTE_W-1:0]   rc;
  word_t               acc_nxt;

  // Substitute the top byte and rotate it to the bottom; after four steps
  // every byte has been substituted and the original order is restored.
  always_comb begin
    acc_nxt = {acc[23:0], sbox(acc[31:24])};
  end

  // Byte-serial substitution sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      rc       <= '0;
      g_done   <= 1'b0;
      g_result <= '0;
    end else begin
      g_done <= 1'b0;
      if (g_start) begin
        acc     <= {g_word[23:0], g_word[31:24]};
        rc      <= rcon(g_round);
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        acc <= acc_nxt;
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          running  <= 1'b0;
          g_done   <= 1'b1;
          g_result <= acc_nxt ^ {rc, 24'h000000};
        end
      end
    end
  end

endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: AES-128 key schedule, one round key per handshake.
// Optional round-key storage with random read port: define KEYEXP_STORE_EN.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
);

  ke_state_t  state;
  ke_state_t  state_nxt;
  word_t      w0, w1, w2, w3;
  word_t      n0, n1, n2, n3;
  word_t      g_q;
  logic [3:0] round;
  logic       g_start;
  logic       g_done;
  word_t      g_result;

  g_word_unit u_g (
    .clk      (clk),
    .rst      (rst),
    .g_start  (g_start),
    .g_word   (w3),
    .g_round  (round + 4'd1),
    .g_done   (g_done),
    .g_result (g_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control outputs.
  always_comb begin
    state_nxt = state;
    key_valid = 1'b0;
    g_start   = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = EMIT;
      EMIT: begin
        key_valid = 1'b1;
        if (key_ready) state_nxt = (round == 4'(LAST_ROUND)) ? DONE : G_START;
      end
      G_START: begin
        g_start   = 1'b1;
        state_nxt = G_WAIT;
      end
      G_WAIT:  if (g_done) state_nxt = EXPAND;
      EXPAND:  state_nxt = EMIT;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next round's words from the current words and the latched g result.
  always_comb begin
    n0 = w0 ^ g_q;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
  end

  // Key-word, round-counter and g-result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      w3    <= '0;
      g_q   <= '0;
      round <= '0;
    end else begin
      case (state)
        LOAD: begin
          w0    <= key_in[127:96];
          w1    <= key_in[95:64];
          w2    <= key_in[63:32];
          w3    <= key_in[31:0];
          round <= '0;
        end
        G_WAIT: if (g_done) g_q <= g_result;
        EXPAND: begin
          w0    <= n0;
          w1    <= n1;
          w2    <= n2;
          w3    <= n3;
          round <= round + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs reflect the held key words directly, so they stay stable in EMIT.
  always_comb begin
    round_key = {w0, w1, w2, w3};
    round_num = round;
  end

`ifdef KEYEXP_STORE_EN
  key_t store [0:10];

  // Each key is written on the edge that enters EMIT for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      store <= '{default: '0};
    end else if (state == LOAD) begin
      store[0] <= key_in;
    end else if (state == EXPAND) begin
      store[round + 4'd1] <= {n0, n1, n2, n3};
    end
  end

  // Combinational read; addresses beyond round 10 return zero.
  always_comb begin
    rd_key = '0;
    if (rd_addr <= 4'd10) rd_key = store[rd_addr];
  end
`else
  logic unused_rd_addr;

  // No storage: read port is inert.
  always_comb begin
    rd_key         = '0;
    unused_rd_addr = ^rd_addr;
  end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: stimulus pushes expected round keys,
// a negedge monitor pops and compares on every accepted key.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .round_key (round_key),
    .round_num (round_num),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_key    (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] key;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  logic [127:0] fips [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  function automatic void check(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  // Monitor: compare every accepted round key against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got round %0d key %h expected no key", round_num, round_key);
      end else begin
        e = sb.pop_front();
        check("sb_round", {124'b0, round_num}, {124'b0, e.round});
        check("sb_key", round_key, e.key);
      end
    end
    if (!rst && done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fips(input int last);
    for (int i = 0; i <= last; i++) sb.push_back('{round: 4'(i), key: fips[i]});
  endtask

  // Full FIPS run with optional round-3 stall and mid-expansion start pulse.
  task automatic run_fips(input bit stall, input bit inject);
    bit stalled;
    bit injected;
    bit seen;
    int dc0;
    stalled  = 0;
    injected = 0;
    seen     = 0;
    dc0      = done_cnt;
    push_fips(10);
    key_in = fips[0];
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("lat_load_valid", {127'b0, key_valid}, 128'd0);
    check("lat_load_busy", {127'b0, busy}, 128'd1);
    tick();
    check("lat_emit_valid", {127'b0, key_valid}, 128'd1);
    check("lat_emit_round", {124'b0, round_num}, 128'd0);
    for (int c = 0; c < 600 && !seen; c++) begin
      if (done) begin
        seen = 1;
      end else begin
        if (stall && !stalled && key_valid && round_num == 4'd3) begin
          key_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            tick();
            check("stall_key", round_key, fips[3]);
            check("stall_round", {124'b0, round_num}, 128'd3);
            check("stall_valid", {127'b0, key_valid}, 128'd1);
          end
          key_ready = 1'b1;
          stalled   = 1;
        end
        if (inject && !injected && round_num == 4'd6) begin
          key_in   = 128'hffffffffffffffffffffffffffffffff;
          start    = 1'b1;
          injected = 1;
          tick();
          start    = 1'b0;
          key_in   = fips[0];
        end else begin
          tick();
        end
      end
    end
    check("done_seen", {127'b0, seen}, 128'd1);
    check("done_key_hold", round_key, fips[10]);
    tick();
    check("idle_done_low", {127'b0, done}, 128'd0);
    check("idle_busy_low", {127'b0, busy}, 128'd0);
    check("idle_key_hold", round_key, fips[10]);
    check("done_pulse_count", 128'(done_cnt - dc0), 128'd1);
    check("sb_drained", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    bit found;
    rst       = 1'b1;
    start     = 1'b0;
    key_in    = '0;
    key_ready = 1'b1;
    rd_addr   = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", {127'b0, key_valid}, 128'd0);
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_done", {127'b0, done}, 128'd0);
    check("rst_round", {124'b0, round_num}, 128'd0);
    check("rst_key", round_key, 128'd0);
    check("rst_rd_key", rd_key, 128'd0);

    // FIPS-197 key with a round-3 stall and a stray start at round 6.
    run_fips(1'b1, 1'b1);

    rd_addr = 4'd10;
    #1;
`ifdef KEYEXP_STORE_EN
    check("store_rd10", rd_key, fips[10]);
    rd_addr = 4'd4;
    #1;
    check("store_rd4", rd_key, fips[4]);
`else
    check("nostore_rd10", rd_key, 128'd0);
    rd_addr = 4'd4;
    #1;
    check("nostore_rd4", rd_key, 128'd0);
`endif
    rd_addr = 4'd12;
    #1;
    check("rd12_zero", rd_key, 128'd0);
    rd_addr = 4'd0;
    tick();

    // All-zero key: rounds 0 and 1, then abort.
    sb.push_back('{round: 4'd0, key: 128'd0});
    sb.push_back('{round: 4'd1, key: 128'h62636363626363636263636362636363});
    key_in = '0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    found  = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (key_valid && round_num == 4'd1) found = 1;
      else tick();
    end
    check("zero_r1_seen", {127'b0, found}, 128'd1);
    tick();
    key_ready = 1'b0;
    check("zero_sb_drained", 128'(sb.size()), 128'd0);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    key_ready = 1'b1;
    check("zero_rst_valid", {127'b0, key_valid}, 128'd0);
    check("zero_rst_key", round_key, 128'd0);

    // Reset while waiting on g in round 5, then a fresh full run.
    push_fips(5);
    key_in = fips[0];
    start  = 1'b1;
    tick();
    start  = 1'b0;
    found  = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (key_valid && round_num == 4'd5) found = 1;
      else tick();
    end
    check("r5_seen", {127'b0, found}, 128'd1);
    tick();
    tick();
    check("gwait_busy", {127'b0, busy}, 128'd1);
    check("gwait_valid", {127'b0, key_valid}, 128'd0);
    rd_addr = 4'd3;
    rst     = 1'b1;
    start   = 1'b1;
    tick();
    rst     = 1'b0;
    start   = 1'b0;
    check("mid_rst_valid", {127'b0, key_valid}, 128'd0);
    check("mid_rst_busy", {127'b0, busy}, 128'd0);
    check("mid_rst_done", {127'b0, done}, 128'd0);
    check("mid_rst_round", {124'b0, round_num}, 128'd0);
    check("mid_rst_key", round_key, 128'd0);
    check("mid_rst_rd_key", rd_key, 128'd0);
    check("mid_rst_sb_drained", 128'(sb.size()), 128'd0);
    tick();
    check("mid_rst_idle_busy", {127'b0, busy}, 128'd0);
    rd_addr = 4'd0;

    run_fips(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
